// File: rtl/unidades_segundos_pkg.sv
// unidades_segundos_pkg: shared FSM encoding, BCD limit and 7-segment table for the units-of-seconds stage
package unidades_segundos_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // gfedcba, active low; anything outside 0..9 blanks the digit
  function automatic logic [6:0] seg7(input logic [3:0] bcd);
    case (bcd)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

endpackage

// File: rtl/unidades_segundos_if.sv
// unidades_segundos_if: control/status bundle of the units stage; seg_u exists only with UNIDADES_7SEG_EN
interface unidades_segundos_if;
  logic       start;
  logic       pause;
  logic       tens_zero;
  logic [3:0] QUSegundos;
  logic       borrow;
  logic       ativo;
  logic       fim;
`ifdef UNIDADES_7SEG_EN
  logic [6:0] seg_u;
`endif

  // controller side: drives commands and the tens-stage status, observes the digit
  modport master (
    output start, pause, tens_zero,
`ifdef UNIDADES_7SEG_EN
    input  seg_u,
`endif
    input  QUSegundos, borrow, ativo, fim
  );

  // timer side
  modport slave (
    input  start, pause, tens_zero,
`ifdef UNIDADES_7SEG_EN
    output seg_u,
`endif
    output QUSegundos, borrow, ativo, fim
  );
endinterface

// File: rtl/unidades_segundos_divisor_1hz.sv
// divisor_1hz: free-running prescaler that pulses tick on the last clock of every TICK_DIV-cycle period while enabled
module divisor_1hz #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  // count only while enabled so a pause freezes the partial second
  always_ff @(posedge clock) begin
    if (!rst_n || clr) r_cnt <= '0;
    else if (en) r_cnt <= tick ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/unidades_segundos.sv
// unidades_segundos: units-of-seconds countdown stage with borrow to tens stage; UNIDADES_7SEG_EN adds the seg_u decoder
module unidades_segundos
  import unidades_segundos_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int START_UNITS = 9
) (
  input  logic               clock,
  input  logic               rst_n,
  unidades_segundos_if.slave bus
);
  localparam logic [3:0] LOAD = (START_UNITS > 9 || START_UNITS < 0) ? BCD_MAX : 4'(START_UNITS);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_q;
  logic [3:0] w_q_next;
  logic       r_borrow;
  logic       w_borrow_next;
  logic       r_fim;
  logic       w_fim_next;
  logic       r_ativo;
  logic       w_tick;
  logic       w_en;

  assign w_en = (r_state == RUN) && !bus.start;

  divisor_1hz #(.TICK_DIV(TICK_DIV)) u_div (
    .clock (clock),
    .rst_n (rst_n),
    .clr   (bus.start),
    .en    (w_en),
    .tick  (w_tick)
  );

  // state and registered outputs
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_borrow <= 1'b0;
      r_fim    <= 1'b0;
      r_ativo  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_q      <= w_q_next;
      r_borrow <= w_borrow_next;
      r_fim    <= w_fim_next;
      r_ativo  <= (w_state_next == RUN) || (w_state_next == PAUSED);
    end
  end

  // next state: start beats everything, completion beats pause
  always_comb begin
    w_state_next = r_state;
    if (bus.start) w_state_next = RUN;
    else if (r_state == RUN)
      w_state_next = (w_tick && r_q == 4'd0 && bus.tens_zero) ? DONE :
                     bus.pause ? PAUSED : RUN;
    else if (r_state == PAUSED)
      w_state_next = bus.pause ? PAUSED : RUN;
  end

  // next digit and pulses; a tick is only ever seen in RUN without start
  always_comb begin
    w_q_next      = r_q;
    w_borrow_next = 1'b0;
    w_fim_next    = 1'b0;
    if (bus.start) w_q_next = LOAD;
    else if (w_tick) begin
      w_q_next      = (r_q == 4'd0) ? (bus.tens_zero ? 4'd0 : BCD_MAX) :
                      (r_q > BCD_MAX) ? BCD_MAX : r_q - 4'd1;
      w_borrow_next = (r_q == 4'd0) && !bus.tens_zero;
      w_fim_next    = (r_q == 4'd0) && bus.tens_zero;
    end
  end

  assign bus.QUSegundos = r_q;
  assign bus.borrow     = r_borrow;
  assign bus.fim        = r_fim;
  assign bus.ativo      = r_ativo;
`ifdef UNIDADES_7SEG_EN
  assign bus.seg_u      = seg7(r_q);
`endif
endmodule

// File: tb/tb_unidades_segundos.sv
// tb_unidades_segundos: directed checks of the units countdown stage with TICK_DIV=4
module tb_unidades_segundos;
  logic clock = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  unidades_segundos_if bus ();

  unidades_segundos #(.TICK_DIV(4), .START_UNITS(9)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // advance n rising edges, then settle on the following falling edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] q, input logic b, input logic f, input logic a);
    chk({tag, ".q"}, 8'(bus.QUSegundos), 8'(q));
    chk({tag, ".borrow"}, 8'(bus.borrow), 8'(b));
    chk({tag, ".fim"}, 8'(bus.fim), 8'(f));
    chk({tag, ".ativo"}, 8'(bus.ativo), 8'(a));
  endtask

`ifdef UNIDADES_7SEG_EN
  logic [6:0] seg_ref [10];
  initial begin
    seg_ref[0] = 7'h40; seg_ref[1] = 7'h79; seg_ref[2] = 7'h24; seg_ref[3] = 7'h30; seg_ref[4] = 7'h19;
    seg_ref[5] = 7'h12; seg_ref[6] = 7'h02; seg_ref[7] = 7'h78; seg_ref[8] = 7'h00; seg_ref[9] = 7'h10;
  end
`endif

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.pause = 1'b0;
    bus.tens_zero = 1'b0;
    @(negedge clock);
    cyc(2);
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    bus.start = 1'b0;
    cyc(3);
    chk_all("idle_after_reset", 4'd0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    chk_all("load", 4'd9, 1'b0, 1'b0, 1'b1);
`ifdef UNIDADES_7SEG_EN
    chk("seg9", 8'(bus.seg_u), 8'(seg_ref[9]));
`endif
    for (int d = 8; d >= 0; d--) begin
      cyc(3);
      chk("hold_before_tick", 8'(bus.QUSegundos), 8'(d + 1));
      cyc(1);
      chk_all("count", 4'(d), 1'b0, 1'b0, 1'b1);
`ifdef UNIDADES_7SEG_EN
      chk("seg", 8'(bus.seg_u), 8'(seg_ref[d]));
`endif
    end
    cyc(4);
    chk_all("wrap_borrow", 4'd9, 1'b1, 1'b0, 1'b1);
    cyc(1);
    chk_all("borrow_drop", 4'd9, 1'b0, 1'b0, 1'b1);
    bus.tens_zero = 1'b1;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    chk("reload_tz", 8'(bus.QUSegundos), 8'd9);
    for (int d = 8; d >= 0; d--) begin
      cyc(4);
      chk("count_tz", 8'(bus.QUSegundos), 8'(d));
    end
    cyc(4);
    chk_all("done", 4'd0, 1'b0, 1'b1, 1'b0);
    cyc(1);
    chk_all("fim_drop", 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(20);
    chk_all("done_hold", 4'd0, 1'b0, 1'b0, 1'b0);
    bus.tens_zero = 1'b0;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(12);
    chk_all("at6", 4'd6, 1'b0, 1'b0, 1'b1);
    cyc(1);
    bus.pause = 1'b1;
    cyc(1);
    chk_all("paused", 4'd6, 1'b0, 1'b0, 1'b1);
    cyc(9);
    chk_all("pause_hold", 4'd6, 1'b0, 1'b0, 1'b1);
    bus.pause = 1'b0;
    cyc(1);
    chk("resume_q", 8'(bus.QUSegundos), 8'd6);
    cyc(1);
    chk("resume_q1", 8'(bus.QUSegundos), 8'd6);
    cyc(1);
    chk("resume_tick", 8'(bus.QUSegundos), 8'd5);
    cyc(8);
    chk("at3", 8'(bus.QUSegundos), 8'd3);
    bus.pause = 1'b1;
    cyc(1);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    chk_all("start_in_paused", 4'd9, 1'b0, 1'b0, 1'b1);
    bus.pause = 1'b0;
    bus.tens_zero = 1'b1;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(40);
    chk_all("done2", 4'd0, 1'b0, 1'b1, 1'b0);
    cyc(1);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    chk_all("start_in_done", 4'd9, 1'b0, 1'b0, 1'b1);
    bus.tens_zero = 1'b0;
    cyc(36);
    chk("at0", 8'(bus.QUSegundos), 8'd0);
    cyc(3);
    rst_n = 1'b0;
    cyc(1);
    chk_all("reset_on_borrow", 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(4);
    chk_all("idle_after_reset2", 4'd0, 1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
